// File: rtl/lose_jingle_player.sv
// Loss jingle generator: four descending square-wave notes per loss, played
// twice once the loss count reaches MAX_COUNT. Sits after the loss counter.
//   state | meaning
//   IDLE  | silent, waiting for a loss pulse
//   ARM   | one cycle for the counter's new value to settle, then sample it
//   TONE  | note note_idx sounding for NOTE_CYCLES cycles
//   GAP   | silence for GAP_CYCLES cycles between notes
module lose_jingle_player #(
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 5_000_000,
  parameter int unsigned HP0         = 95_602,
  parameter int unsigned HP1         = 127_551,
  parameter int unsigned HP2         = 151_515,
  parameter int unsigned HP3         = 190_840,
  parameter int unsigned MAX_COUNT   = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  logic [3:0] lose_count,
  input  logic       mute,
  output logic       audio_out,
  output logic       busy,
  output logic [1:0] note_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_TONE, S_GAP} state_t;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] HP_LAST0  = 32'(HP0 - 1);
  localparam logic [31:0] HP_LAST1  = 32'(HP1 - 1);
  localparam logic [31:0] HP_LAST2  = 32'(HP2 - 1);
  localparam logic [31:0] HP_LAST3  = 32'(HP3 - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_hp, w_hp_nxt;
  logic        r_phase, w_phase_nxt;
  logic        r_repeat, w_repeat_nxt;
  logic        r_round, w_round_nxt;
  logic [1:0]  r_note, w_note_nxt;
  logic        r_audio, w_audio_nxt;
  logic        r_busy, w_busy_nxt;
  logic [31:0] w_hp_last;

  always_comb begin
    w_hp_last = HP_LAST0;
    case (r_note)
      2'd1:    w_hp_last = HP_LAST1;
      2'd2:    w_hp_last = HP_LAST2;
      2'd3:    w_hp_last = HP_LAST3;
      default: w_hp_last = HP_LAST0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_hp_nxt     = r_hp;
    w_phase_nxt  = r_phase;
    w_repeat_nxt = r_repeat;
    w_round_nxt  = r_round;
    w_note_nxt   = r_note;
    unique case (r_state)
      S_IDLE: begin
        if (trigger) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        w_repeat_nxt = ({28'd0, lose_count} >= MAX_COUNT);
        w_round_nxt  = 1'b0;
        w_note_nxt   = 2'd0;
        w_cnt_nxt    = NOTE_LAST;
        w_hp_nxt     = '0;
        w_phase_nxt  = 1'b0;
        w_state_nxt  = S_TONE;
      end
      S_TONE: begin
        if (r_cnt == '0) begin
          w_hp_nxt    = '0;
          w_phase_nxt = 1'b0;
          if (r_note != 2'd3) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LAST;
          end else if (r_repeat && !r_round) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LAST;
            w_round_nxt = 1'b1;
          end else begin
            // last note of the last round ends with no trailing gap
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
          if (r_hp == w_hp_last) begin
            w_hp_nxt    = '0;
            w_phase_nxt = ~r_phase;
          end else begin
            w_hp_nxt = r_hp + 32'd1;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_TONE;
          w_cnt_nxt   = NOTE_LAST;
          w_hp_nxt    = '0;
          w_phase_nxt = 1'b0;
          w_note_nxt  = r_note + 2'd1;
        end else begin
          w_cnt_nxt = r_cnt - 32'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_audio_nxt = w_phase_nxt && (w_state_nxt == S_TONE) && !mute;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hp     <= '0;
      r_phase  <= 1'b0;
      r_repeat <= 1'b0;
      r_round  <= 1'b0;
      r_note   <= 2'd0;
      r_audio  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_hp     <= w_hp_nxt;
      r_phase  <= w_phase_nxt;
      r_repeat <= w_repeat_nxt;
      r_round  <= w_round_nxt;
      r_note   <= w_note_nxt;
      r_audio  <= w_audio_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign audio_out = r_audio;
  assign busy      = r_busy;
  assign note_idx  = r_note;

endmodule

// File: tb/tb_lose_jingle_player.sv
// Scoreboard bench for lose_jingle_player: stimulus queues the expected shape
// of each jingle, a monitor measures every busy episode and compares.
module tb_lose_jingle_player;

  logic       clk;
  logic       rst_n;
  logic       trigger;
  logic [3:0] lose_count;
  logic       mute;
  logic       audio_out;
  logic       busy;
  logic [1:0] note_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int len;
    int rises;
    int highs;
    int nseq;
    int nsum;
    int mlo;
    int mhi;
    bit full;
  } exp_t;

  exp_t exp_q[$];

  lose_jingle_player #(
    .NOTE_CYCLES(20), .GAP_CYCLES(4),
    .HP0(2), .HP1(3), .HP2(4), .HP3(5), .MAX_COUNT(9)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .lose_count(lose_count),
    .mute(mute), .audio_out(audio_out), .busy(busy), .note_idx(note_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_exp(input int len, input int rises, input int highs,
                          input int nseq, input int nsum, input int mlo,
                          input int mhi, input bit full);
    exp_t e;
    e.len = len; e.rises = rises; e.highs = highs; e.nseq = nseq;
    e.nsum = nsum; e.mlo = mlo; e.mhi = mhi; e.full = full;
    exp_q.push_back(e);
  endtask

  // returns at the negedge of busy cycle 1 (the ARM cycle)
  task automatic pulse(input logic [3:0] lc_trig, input logic [3:0] lc_arm);
    @(negedge clk);
    trigger = 1'b1;
    lose_count = lc_trig;
    @(negedge clk);
    trigger = 1'b0;
    lose_count = lc_arm;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy still high after %0d cycles expected low", budget);
    end
  endtask

  // monitor: one record per busy episode
  exp_t       cur;
  bit         have_cur = 1'b0;
  int         cyc, rises, highs, win_highs, nseq, nsum;
  logic       prev_busy = 1'b0;
  logic       prev_audio = 1'b0;
  logic [1:0] prev_note = 2'd0;

  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_jingle got busy=1 expected no jingle");
        have_cur = 1'b0;
      end else begin
        cur = exp_q.pop_front();
        have_cur = 1'b1;
      end
      cyc = 0; rises = 0; highs = 0; win_highs = 0; nseq = 0; nsum = 0;
    end
    if (busy === 1'b1) begin
      cyc++;
      if (audio_out === 1'b1) begin
        highs++;
        if (prev_audio !== 1'b1) rises++;
        if (cyc >= cur.mlo && cyc <= cur.mhi) win_highs++;
      end
      if (cyc == 2) begin
        nseq = int'(note_idx);
      end else if (cyc > 2 && note_idx != prev_note) begin
        nseq = (nseq << 2) | int'(note_idx);
        nsum += cyc;
      end
    end else if (prev_busy === 1'b1 && have_cur) begin
      chk("busy_len", cyc, cur.len);
      if (cur.full) begin
        chk("audio_rises", rises, cur.rises);
        chk("audio_high_cycles", highs, cur.highs);
        chk("note_sequence", nseq, cur.nseq);
        chk("note_change_cycle_sum", nsum, cur.nsum);
        chk("audio_after_busy", int'(audio_out), 0);
        if (cur.mhi != 0) chk("muted_window_highs", win_highs, 0);
      end
      have_cur = 1'b0;
    end
    prev_busy  = busy;
    prev_audio = audio_out;
    prev_note  = note_idx;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    trigger = 1'b1;
    lose_count = 4'd0;
    mute = 1'b0;

    // reset overrides a held trigger
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_audio", int'(audio_out), 0);
      chk("reset_note", int'(note_idx), 0);
    end
    rst_n = 1'b1;
    trigger = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_after_reset", int'(busy), 0);
    end

    // single jingle: 1+4*20+3*4 cycles, 12 pulses, 37 high cycles
    push_exp(93, 12, 37, 27, 150, 0, 0, 1'b1);
    pulse(4'd3, 4'd3);
    wait_idle(300);
    repeat (5) @(negedge clk);

    // game over: count reaches 9 only in the ARM cycle
    push_exp(189, 24, 74, 6939, 686, 0, 0, 1'b1);
    pulse(4'd8, 4'd9);
    @(negedge clk);
    lose_count = 4'd2;
    wait_idle(400);
    repeat (5) @(negedge clk);

    // triggers while busy and on the last TONE cycle are dropped
    push_exp(93, 12, 37, 27, 150, 0, 0, 1'b1);
    lose_count = 4'd3;
    pulse(4'd3, 4'd3);
    repeat (29) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    push_exp(93, 12, 37, 27, 150, 0, 0, 1'b1);
    repeat (62) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    chk("busy_low_after_jingle", int'(busy), 0);
    @(negedge clk);
    trigger = 1'b0;
    chk("rearm_next_cycle", int'(busy), 1);
    wait_idle(300);
    repeat (5) @(negedge clk);

    // mute from busy cycle 10 through 50
    push_exp(93, 6, 22, 27, 150, 10, 50, 1'b1);
    pulse(4'd3, 4'd3);
    repeat (8) @(negedge clk);
    mute = 1'b1;
    repeat (41) @(negedge clk);
    mute = 1'b0;
    wait_idle(300);
    repeat (5) @(negedge clk);

    // reset in the middle of note 1
    push_exp(30, 0, 0, 0, 0, 0, 0, 1'b0);
    pulse(4'd3, 4'd3);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_audio", int'(audio_out), 0);
    chk("midreset_note", int'(note_idx), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    push_exp(93, 12, 37, 27, 150, 0, 0, 1'b1);
    pulse(4'd3, 4'd3);
    wait_idle(300);
    repeat (10) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
